mdu_iterative: RTL
==================

Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit (MDU) for the MIPS pipeline; successor to the single-cycle ALU for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Sits beside the EX-stage ALU. Owns the architectural HI/LO registers.
- Uses a start/busy/done handshake, so the pipeline stalls MFHI/MFLO while busy.
- Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up for signed ops.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 4.
- CW, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- cancel  input  1  pipeline flush; aborts the operation in flight.
- mdu_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- in_1  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- in_2  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse when HI/LO have been updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- done is registered. It is 0 in every cycle except the one following a completing edge.
- IDLE, start=1, cancel=0, op in 000..011:
  - Latch operands. For signed ops latch magnitudes, plus the result-sign flags.
  - counter=WIDTH, busy=1, go to CALC.
- IDLE, start=1, cancel=0, op 100/101:
  - hi (or lo) <= in_1 on this edge.
  - done=1 next cycle; busy stays 0; no state change.
- Reserved ops, or start=0: no effect.
- Start with cancel=1 in the same cycle: cancel wins; nothing is latched.
- CALC, one iteration per edge, counter decrements:
  - Multiply: if multiplier LSB is set, add the multiplicand into the upper half of the 2*WIDTH accumulator; then shift right 1.
  - Divide (restoring): shift {rem,quot} left 1; trial-subtract the divisor from rem; if non-negative, keep the result and set the quotient LSB.
  - When counter reaches 1 on an edge, go to FIX.
- FIX (one edge):
  - Apply sign correction.
    - Product negated when signs differ.
    - Quotient negated when signs differ.
    - Remainder takes the dividend's sign.
  - Write {hi,lo}: multiply -> hi=product[2W-1:W], lo=product[W-1:0]; divide -> lo=quotient, hi=remainder.
  - busy=0, done=1 next cycle, go to IDLE.
- Latency: start accepted at edge 0 -> busy=1 after edge 0. CALC occupies edges 1..WIDTH. FIX at edge WIDTH+1 updates hi/lo and drops busy, with done high in the following cycle. Total WIDTH+1 edges.
- start while busy: ignored. The pipeline must stall and re-issue the request.
- cancel while busy (CALC or FIX): return to IDLE on that edge with busy=0, hi/lo unchanged, no done.
- Divide by zero (in_2=0, DIV or DIVU): still WIDTH+1 cycles; lo=all ones, hi=in_1 (raw, unsigned/unmodified). Defined here, not UNPREDICTABLE.
- Signed overflow (DIV, most-negative / -1): lo=most-negative (wraps), hi=0.
- Most-negative operand magnitudes are handled in WIDTH+1-bit internal arithmetic so MULT does not overflow.
- hi/lo change only at FIX, MTHI/MTLO, or reset. in_1/in_2 may change freely after acceptance.

Test Plan:
- MULT in_1=0xFFFFFFFE, in_2=0x00000003 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse exactly 1 cycle.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV in_1=0xFFFFFFF9 (-7), in_2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007 after 33 cycles.
- Start DIVU 100/7 with hi=lo=0x12345678 preset via MTHI/MTLO. Assert cancel at cycle 10 -> busy=0 next edge, no done, hi/lo still 0x12345678. A start at cycle 5 is ignored.
- Start MULT, drop reset_n asynchronously mid-CALC -> immediately busy=0, done=0, hi=lo=0. After release, MTLO 0xA5A5A5A5 -> lo updated on the accepting edge, done 1 cycle, busy never high.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide at one bit per clock, operating on magnitudes with a final sign fix-up.
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cancel,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next, div_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic [W2-1:0]    prod_f;
    logic [WIDTH-1:0] quot_f, rem_f;

    always_comb begin
        signed_op = ~mdu_op[0];
        a_neg     = signed_op & in_1[WIDTH-1];
        b_neg     = signed_op & in_2[WIDTH-1];
        a_mag     = a_neg ? -in_1 : in_1;
        b_mag     = b_neg ? -in_2 : in_2;

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc = {remainder, dividend/quotient}; remainder stays below divisor
        div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        if (div_shift >= {1'b0, opb_q})
            div_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        prod_f = neg_res_q ? (W2'(0) - acc_q) : acc_q;
        quot_f = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_f  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    case (mdu_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d  = mdu_op[1];
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = mdu_op[1] && (in_2 == '0);
                            opb_d     = mdu_op[1] ? b_mag : a_mag;
                            acc_d     = {{WIDTH{1'b0}}, (mdu_op[1] ? a_mag : b_mag)};
                            cnt_d     = CW'(WIDTH);
                            state_d   = CALC;
                        end
                        3'b100: begin
                            hi_d   = in_1;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = in_1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Divide by zero: remainder sign-fix restores the raw dividend
                        lo_d = dz_q ? {WIDTH{1'b1}} : quot_f;
                        hi_d = rem_f;
                    end else begin
                        hi_d = prod_f[W2-1:WIDTH];
                        lo_d = prod_f[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
